// File: rtl/veriyolu_hakemi_pkg.sv
// veriyolu_hakemi_pkg: grant state encodings and lock-starvation limit for the veriyolu arbiter
package veriyolu_hakemi_pkg;
  typedef enum logic [1:0] {
    HAKEM_BOS = 2'd0,
    HAKEM_M0  = 2'd1,
    HAKEM_M1  = 2'd2
  } hakem_durum_t;
  localparam int HAKEM_KILIT_SINIR = 8;
  localparam int HAKEM_SAYAC_W = $clog2(HAKEM_KILIT_SINIR + 1);
endpackage

// File: rtl/hakem_secici.sv
// hakem_secici: idle-state winner pick; round-robin on ties with VERIYOLU_HAKEMI_DONGUSEL_EN, else requester 0 first
module hakem_secici (
  input  logic m0_sec,
  input  logic m1_sec,
`ifdef VERIYOLU_HAKEMI_DONGUSEL_EN
  input  logic son_hizmet,
`endif
  output logic gecerli,
  output logic kazanan
);
  // kazanan=1 selects requester 1; only meaningful when gecerli is high
  always_comb begin
    gecerli = m0_sec | m1_sec;
`ifdef VERIYOLU_HAKEMI_DONGUSEL_EN
    kazanan = (m0_sec & m1_sec) ? ~son_hizmet : m1_sec;
`else
    kazanan = m1_sec & ~m0_sec;
`endif
  end
endmodule

// File: rtl/veriyolu_hakemi.sv
// veriyolu_hakemi: two-requester arbiter for the vy_* bus port; VERIYOLU_HAKEMI_DONGUSEL_EN enables round-robin ties
module veriyolu_hakemi
  import veriyolu_hakemi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_adres_i,
  input  logic [31:0] m0_veri_i,
  input  logic [3:0]  m0_veri_maske_i,
  input  logic        m0_sec_i,
  input  logic        m0_kilit_i,
  output logic [31:0] m0_veri_o,
  output logic        m0_durdur_o,
  input  logic [31:0] m1_adres_i,
  input  logic [31:0] m1_veri_i,
  input  logic [3:0]  m1_veri_maske_i,
  input  logic        m1_sec_i,
  input  logic        m1_kilit_i,
  output logic [31:0] m1_veri_o,
  output logic        m1_durdur_o,
  output logic [31:0] vy_adres_o,
  output logic [31:0] vy_veri_o,
  output logic [3:0]  vy_veri_maske_o,
  output logic        vy_sec_o,
  input  logic [31:0] vy_veri_i,
  input  logic        vy_durdur_i
);
  hakem_durum_t durum, durum_sonraki, diger;
  logic [HAKEM_SAYAC_W-1:0] sayac, sayac_sonraki;
  logic verilen, bagli, x_sec, x_kilit, y_sec, tamam, kilit_ok;
  logic gecerli, kazanan;
`ifdef VERIYOLU_HAKEMI_DONGUSEL_EN
  logic son_hizmet;
  // remember who completed last so idle-state ties alternate
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) son_hizmet <= 1'b1;
    else if (tamam) son_hizmet <= verilen;
`endif
  hakem_secici u_secici (
    .m0_sec     (m0_sec_i),
    .m1_sec     (m1_sec_i),
`ifdef VERIYOLU_HAKEMI_DONGUSEL_EN
    .son_hizmet (son_hizmet),
`endif
    .gecerli    (gecerli),
    .kazanan    (kazanan)
  );
  // grant state and consecutive-lock counter
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      durum <= HAKEM_BOS;
      sayac <= '0;
    end else begin
      durum <= durum_sonraki;
      sayac <= sayac_sonraki;
    end
  // request mux toward the bus, response demux back, and next grant
  always_comb begin
    verilen = durum == HAKEM_M1;
    bagli = durum != HAKEM_BOS;
    x_sec = verilen ? m1_sec_i : m0_sec_i;
    x_kilit = verilen ? m1_kilit_i : m0_kilit_i;
    y_sec = verilen ? m0_sec_i : m1_sec_i;
    diger = verilen ? HAKEM_M0 : HAKEM_M1;
    vy_sec_o = bagli & x_sec;
    vy_adres_o = !bagli ? '0 : verilen ? m1_adres_i : m0_adres_i;
    vy_veri_o = !bagli ? '0 : verilen ? m1_veri_i : m0_veri_i;
    vy_veri_maske_o = !bagli ? '0 : verilen ? m1_veri_maske_i : m0_veri_maske_i;
    tamam = vy_sec_o & ~vy_durdur_i;
    kilit_ok = x_kilit & (sayac != HAKEM_SAYAC_W'(HAKEM_KILIT_SINIR));
    durum_sonraki = !bagli ? (gecerli ? (kazanan ? HAKEM_M1 : HAKEM_M0) : HAKEM_BOS)
                  : !x_sec ? HAKEM_BOS
                  : (!tamam || kilit_ok) ? durum
                  : y_sec ? diger : HAKEM_BOS;
    sayac_sonraki = (durum_sonraki != durum) ? '0
                  : (tamam & kilit_ok & y_sec) ? sayac + 1'b1 : sayac;
    m0_durdur_o = (durum == HAKEM_M0) ? vy_durdur_i & m0_sec_i : m0_sec_i;
    m1_durdur_o = (durum == HAKEM_M1) ? vy_durdur_i & m1_sec_i : m1_sec_i;
    m0_veri_o = (durum == HAKEM_M0) ? vy_veri_i : '0;
    m1_veri_o = (durum == HAKEM_M1) ? vy_veri_i : '0;
  end
endmodule
